// File: rtl/seviye_dugum_uretici.sv
// rtl/seviye_dugum_uretici.sv - streams every heap node index on a requested tree level
module seviye_dugum_uretici #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         baslat,
    input  logic [2:0]   seviye,
    input  logic         iptal,
    input  logic         hazir,
    output logic [W-1:0] dugum,
    output logic         gecerli,
    output logic         son,
    output logic         mesgul,
    output logic         hata
);

    typedef enum logic {
        IDLE,
        RUN
    } durum_t;

    // Deepest legal level; level W is the truncated single-node level.
    localparam logic [2:0]   UST_SEVIYE = 3'(W);
    localparam logic [W-1:0] BIR        = W'(1);
    localparam logic [W-1:0] IKI        = W'(2);

    durum_t       durum;
    durum_t       durum_next;
    logic [W-1:0] dugum_next;
    logic [W-1:0] son_idx;
    logic [W-1:0] son_idx_next;
    logic         hata_next;

    logic         seviye_gecerli;
    logic [W-1:0] bas_hesap;
    logic [W-1:0] son_hesap;

    // Start and last index of the requested level. Modular W-bit arithmetic
    // yields exactly the low W bits of the W+1-bit values 2^L-1 and
    // 2^(L+1)-2, so the truncation is implicit (2^W wraps to 0, minus 1 is 2^W-1).
    always_comb begin
        seviye_gecerli = (seviye <= UST_SEVIYE);
        bas_hesap      = (BIR << seviye) - BIR;
        if (seviye < UST_SEVIYE) begin
            son_hesap = (BIR << (seviye + 3'd1)) - IKI;
        end else begin
            son_hesap = bas_hesap;
        end
    end

    // Next-state logic: accept a start in IDLE, advance on each transfer in RUN.
    always_comb begin
        durum_next   = durum;
        dugum_next   = dugum;
        son_idx_next = son_idx;
        hata_next    = 1'b0;
        case (durum)
            IDLE: begin
                if (baslat) begin
                    if (seviye_gecerli) begin
                        durum_next   = RUN;
                        dugum_next   = bas_hesap;
                        son_idx_next = son_hesap;
                    end else begin
                        hata_next = 1'b1;
                    end
                end
            end
            RUN: begin
                if (iptal) begin
                    durum_next = IDLE;
                end else if (hazir) begin
                    if (son) begin
                        durum_next = IDLE;
                    end else begin
                        dugum_next = dugum + BIR;
                    end
                end
            end
            default: begin
                durum_next = IDLE;
            end
        endcase
    end

    // State, current index, latched last index and the error pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            durum   <= IDLE;
            dugum   <= '0;
            son_idx <= '0;
            hata    <= 1'b0;
        end else begin
            durum   <= durum_next;
            dugum   <= dugum_next;
            son_idx <= son_idx_next;
            hata    <= hata_next;
        end
    end

    // Handshake outputs derive from state only; son compares against the latched last index.
    always_comb begin
        gecerli = (durum == RUN);
        mesgul  = (durum == RUN);
        son     = (durum == RUN) && (dugum == son_idx);
    end

endmodule

// File: tb/tb_seviye_dugum_uretici.sv
// tb/tb_seviye_dugum_uretici.sv - randomized and directed bench with a level-to-index reference model
module tb_seviye_dugum_uretici;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         baslat = 1'b0;
    logic [2:0]   seviye = 3'd0;
    logic         iptal = 1'b0;
    logic         hazir = 1'b0;
    logic [W-1:0] dugum;
    logic         gecerli;
    logic         son;
    logic         mesgul;
    logic         hata;

    int n_cmp = 0;
    int n_err = 0;
    int pat[$];

    seviye_dugum_uretici #(.W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .baslat  (baslat),
        .seviye  (seviye),
        .iptal   (iptal),
        .hazir   (hazir),
        .dugum   (dugum),
        .gecerli (gecerli),
        .son     (son),
        .mesgul  (mesgul),
        .hata    (hata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; starts a stream and follows it to completion.
    // mode: 0 hazir always high, 1 random hazir, 2 hazir from pat[].
    task automatic run_stream(input int lvl, input int mode, input int abort_at,
                              input int rst_at, input bit junk);
        int q[$];
        int first;
        int cnt;
        int cyc;
        bit hz;
        bit done;
        first = (1 << lvl) - 1;
        cnt   = (lvl < W) ? (1 << lvl) : 1;
        for (int i = 0; i < cnt; i++) q.push_back(first + i);

        baslat = 1'b1;
        seviye = 3'(lvl);
        hazir  = 1'b0;
        iptal  = 1'b0;
        @(negedge clk);
        baslat = 1'b0;
        seviye = 3'($urandom_range(0, 7));

        cyc  = 0;
        done = 1'b0;
        while (q.size() > 0 && cyc < 200 && !done) begin
            chk("gecerli_run", 32'(gecerli), 32'd1);
            chk("mesgul_run", 32'(mesgul), 32'd1);
            chk("dugum", 32'(dugum), 32'(q[0]));
            chk("son", 32'(son), (q.size() == 1) ? 32'd1 : 32'd0);
            chk("hata_run", 32'(hata), 32'd0);
            if (q[0] == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_dugum", 32'(dugum), 32'd0);
                chk("rst_gecerli", 32'(gecerli), 32'd0);
                chk("rst_son", 32'(son), 32'd0);
                chk("rst_mesgul", 32'(mesgul), 32'd0);
                chk("rst_hata", 32'(hata), 32'd0);
                @(negedge clk);
                rst_n  = 1'b1;
                hazir  = 1'b1;
                baslat = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("post_rst_gecerli", 32'(gecerli), 32'd0);
                    chk("post_rst_mesgul", 32'(mesgul), 32'd0);
                end
                return;
            end
            if (mode == 0) begin
                hz = 1'b1;
            end else if (mode == 1) begin
                hz = (($urandom % 4) != 0);
            end else begin
                hz = (cyc < pat.size()) ? (pat[cyc] != 0) : 1'b1;
            end
            hazir  = hz;
            iptal  = (q[0] == abort_at);
            baslat = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            seviye = 3'($urandom_range(0, 7));
            done   = iptal;
            if (hz) void'(q.pop_front());
            @(negedge clk);
            cyc++;
        end
        if (!done && q.size() > 0) chk("timeout", 32'(q.size()), 32'd0);
        hazir  = 1'b0;
        iptal  = 1'b0;
        baslat = 1'b0;
        chk("gecerli_end", 32'(gecerli), 32'd0);
        chk("mesgul_end", 32'(mesgul), 32'd0);
    endtask

    // Called at a negedge; an out-of-range level must give a single hata pulse.
    task automatic err_level(input int lvl);
        baslat = 1'b1;
        seviye = 3'(lvl);
        @(negedge clk);
        baslat = 1'b0;
        chk("hata_pulse", 32'(hata), 32'd1);
        chk("hata_gecerli", 32'(gecerli), 32'd0);
        chk("hata_mesgul", 32'(mesgul), 32'd0);
        @(negedge clk);
        chk("hata_drop", 32'(hata), 32'd0);
        chk("hata_gecerli2", 32'(gecerli), 32'd0);
    endtask

    initial begin
        int lv;
        int ab;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_dugum", 32'(dugum), 32'd0);
        chk("reset_gecerli", 32'(gecerli), 32'd0);
        chk("reset_son", 32'(son), 32'd0);
        chk("reset_mesgul", 32'(mesgul), 32'd0);
        chk("reset_hata", 32'(hata), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_stream(0, 0, -1, -1, 1'b0);
        run_stream(3, 0, -1, -1, 1'b0);
        pat = '{1, 0, 0, 1, 1, 0, 1};
        run_stream(2, 2, -1, -1, 1'b0);
        run_stream(4, 0, -1, -1, 1'b0);
        err_level(5);
        run_stream(3, 0, 9, -1, 1'b1);
        run_stream(1, 0, -1, -1, 1'b0);
        run_stream(3, 0, -1, 10, 1'b0);

        iptal = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("idle_iptal", 32'(gecerli), 32'd0);
        end
        iptal = 1'b0;

        for (int t = 0; t < 30; t++) begin
            lv = $urandom_range(0, 7);
            if (lv > W) begin
                err_level(lv);
            end else begin
                ab = -1;
                if (($urandom % 4) == 0) begin
                    ab = ((1 << lv) - 1) + $urandom_range(0, (lv < W) ? (1 << lv) - 1 : 0);
                end
                run_stream(lv, 1, ab, -1, 1'b1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
